pkt_router_buffered: RTL and testbench
======================================

// Module: pkt_router_buffered
// PURPOSE
//  Parametrised successor of the 4-way packet router: accepts packets as flits on one
//  valid/ready input, routes every flit of a packet to the output port named by the
//  head flit, and buffers per output in a FIFO with independent valid/ready drain.
//  Reserved packet types and out-of-range destinations are dropped whole and flagged.
// PARAMETERS
//  NUM_PORTS   4  number of output ports (2..16)
//  DATA_W      8  payload bits per flit
//  TYPE_W      2  packet-type bits; type value all-ones is reserved (invalid)
//  FIFO_DEPTH  4  entries per output FIFO (power of 2, >=2)
//  DEST_W      $clog2(NUM_PORTS)  destination field width (derived, do not override)
// PORTS
//  clk             in   1                  clock, rising edge
//  n_rst           in   1                  asynchronous active-low reset
//  in_valid        in   1                  input flit valid
//  in_ready        out  1                  input flit accepted when in_valid & in_ready
//  in_dest         in   DEST_W             destination port; sampled on head flit only
//  in_type         in   TYPE_W             packet type; sampled on head flit only
//  in_data         in   DATA_W             flit payload
//  in_eop          in   1                  last flit of packet
//  out_valid       out  NUM_PORTS          per-port FIFO non-empty
//  out_ready       in   NUM_PORTS          per-port downstream pop
//  out_flit        out  NUM_PORTS*F        per-port {eop,type,data}, F=1+TYPE_W+DATA_W, port p at [p*F +: F]
//  invalid_packet  out  1                  1-cycle pulse on accept of an invalid head flit
//  drop_count      out  8                  saturating count of dropped packets
// BEHAVIOUR
//  Reset (n_rst=0, async): state IDLE, all FIFOs empty, out_valid=0, invalid_packet=0,
//   drop_count=0, latched dest/type=0. in_ready=1 in the first cycle after release.
//  FSM states: IDLE (await head flit), ROUTE (mid-packet to latched port), DROP (discard).
//  IDLE, accepted flit: invalid if in_type=all-ones or in_dest>=NUM_PORTS.
//   - valid, in_eop=1: single-flit packet pushed, stay IDLE.
//   - valid, in_eop=0: latch dest/type, push, -> ROUTE.
//   - invalid: no push, invalid_packet=1 next cycle, drop_count+1 (saturate at 255);
//     in_eop=1 -> stay IDLE, else -> DROP.
//  ROUTE: each accepted flit pushed to latched port carrying latched type (in_dest/in_type
//   ignored); in_eop=1 -> IDLE.
//  DROP: in_ready=1 unconditionally; flits discarded; in_eop=1 -> IDLE.
//  in_ready (IDLE/ROUTE) = target FIFO not full; target = in_dest in IDLE
//   (invalid head: in_ready=1), latched dest in ROUTE. Purely from registered occupancy;
//   no full-bypass: pop and push on a full FIFO in the same cycle does not accept.
//  FIFO: first-word fall-through; an accepted flit appears at out_flit/out_valid on the
//   next rising edge (latency 1). Pop when out_valid[p] & out_ready[p]. Simultaneous
//   push+pop on a non-full, non-empty FIFO keeps count. Pointers wrap modulo FIFO_DEPTH.
//  out_flit[p] is don't-care while out_valid[p]=0; bench must not check it.
//  Ports drain independently; a stalled port blocks input only while it is the target.
//  Reset mid-packet discards all buffered flits and the partial packet; next accepted
//   flit is treated as a head flit.
//  in_valid=0 never changes state; no flit is lost or duplicated under backpressure.
// TESTING
//  T1 single flit dest=1,type=1,data=AB,eop=1, out_ready=all 1 -> one cycle later
//     out_valid=0010, out_flit[1]={1,01,AB}; other ports stay empty.
//  T2 3-flit packet dest=2 type=0 data 11,22,33 with in_dest toggling on flits 2-3 ->
//     all three on port 2 in order with type 0, eop only on 33.
//  T3 out_ready[0]=0, stream 6 single-flit packets to port 0 (DEPTH 4) -> in_ready drops
//     after 4th accept; raise out_ready -> remaining 2 accepted, 6 flits out in order.
//  T4 head type=11, 3 flits -> invalid_packet pulses once, drop_count=1, in_ready=1
//     throughout, no out_valid; next valid packet routed normally.
//  T5 NUM_PORTS=3 build: head dest=3 -> dropped as invalid, drop_count=1.
//  T6 assert n_rst mid-ROUTE with 2 flits buffered -> out_valid=0 immediately; next
//     flit routed by its own in_dest.

Source files
------------

// File: rtl/pkt_router_buffered.sv
// rtl/pkt_router_buffered.sv - packet router with per-output FWFT FIFOs
// Head flit selects the output; reserved types / out-of-range destinations are dropped whole.
module pkt_router_buffered #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_W     = 8,
   parameter int TYPE_W     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int DEST_W     = $clog2(NUM_PORTS)
) (
   input  logic                                    clk,
   input  logic                                    n_rst,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [DEST_W-1:0]                       in_dest,
   input  logic [TYPE_W-1:0]                       in_type,
   input  logic [DATA_W-1:0]                       in_data,
   input  logic                                    in_eop,
   output logic [NUM_PORTS-1:0]                    out_valid,
   input  logic [NUM_PORTS-1:0]                    out_ready,
   output logic [NUM_PORTS*(1+TYPE_W+DATA_W)-1:0]  out_flit,
   output logic                                    invalid_packet,
   output logic [7:0]                              drop_count
);
   localparam int F     = 1 + TYPE_W + DATA_W;
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUTE = 2'd1, S_DROP = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [DEST_W-1:0]   dest_q, dest_d;
   logic [TYPE_W-1:0]   type_q, type_d;
   logic                invalid_q, invalid_d;
   logic [7:0]          drop_q, drop_d;

   logic [F-1:0]        mem_q    [NUM_PORTS][FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q [NUM_PORTS];
   logic [PTR_W-1:0]    rd_ptr_q [NUM_PORTS];
   logic [PTR_W:0]      count_q  [NUM_PORTS];

   logic [NUM_PORTS-1:0] full, push, pop;
   logic                 head_invalid, tgt_full, accept, do_push;
   logic [DEST_W-1:0]    tgt;
   logic [F-1:0]         push_flit;

   always_comb begin
      out_valid = '0;
      out_flit  = '0;
      full      = '0;
      pop       = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         full[p]            = (count_q[p] == (PTR_W+1)'(FIFO_DEPTH));
         out_valid[p]       = (count_q[p] != '0);
         pop[p]             = out_valid[p] & out_ready[p];
         out_flit[p*F +: F] = mem_q[p][rd_ptr_q[p]];
      end
   end

   assign head_invalid = (in_type == {TYPE_W{1'b1}}) || (32'(in_dest) >= 32'(NUM_PORTS));
   assign tgt          = (state_q == S_ROUTE) ? dest_q : in_dest;

   // Readiness uses registered occupancy only: a pop in the same cycle does not free a slot.
   always_comb begin
      tgt_full = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (tgt == DEST_W'(p)) tgt_full = full[p];
      end
   end

   always_comb begin
      state_d   = state_q;
      dest_d    = dest_q;
      type_d    = type_q;
      invalid_d = 1'b0;
      drop_d    = drop_q;
      do_push   = 1'b0;
      case (state_q)
         S_IDLE:  in_ready = head_invalid | ~tgt_full;
         S_ROUTE: in_ready = ~tgt_full;
         default: in_ready = 1'b1;
      endcase
      accept = in_valid & in_ready;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (head_invalid) begin
                  invalid_d = 1'b1;
                  if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                  if (!in_eop) state_d = S_DROP;
               end else begin
                  do_push = 1'b1;
                  if (!in_eop) begin
                     state_d = S_ROUTE;
                     dest_d  = in_dest;
                     type_d  = in_type;
                  end
               end
            end
         end
         S_ROUTE: begin
            if (accept) begin
               do_push = 1'b1;
               if (in_eop) state_d = S_IDLE;
            end
         end
         S_DROP: begin
            if (accept && in_eop) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      push = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         push[p] = do_push & (tgt == DEST_W'(p));
      end
   end

   assign push_flit      = {in_eop, (state_q == S_ROUTE) ? type_q : in_type, in_data};
   assign invalid_packet = invalid_q;
   assign drop_count     = drop_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= S_IDLE;
         dest_q    <= '0;
         type_q    <= '0;
         invalid_q <= 1'b0;
         drop_q    <= '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            wr_ptr_q[p] <= '0;
            rd_ptr_q[p] <= '0;
            count_q[p]  <= '0;
         end
      end else begin
         state_q   <= state_d;
         dest_q    <= dest_d;
         type_q    <= type_d;
         invalid_q <= invalid_d;
         drop_q    <= drop_d;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (push[p]) wr_ptr_q[p] <= wr_ptr_q[p] + PTR_W'(1);
            if (pop[p])  rd_ptr_q[p] <= rd_ptr_q[p] + PTR_W'(1);
            case ({push[p], pop[p]})
               2'b10:   count_q[p] <= count_q[p] + (PTR_W+1)'(1);
               2'b01:   count_q[p] <= count_q[p] - (PTR_W+1)'(1);
               default: count_q[p] <= count_q[p];
            endcase
         end
      end
   end

   // Storage needs no reset: occupancy gates visibility of every entry.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (push[p]) mem_q[p][wr_ptr_q[p]] <= push_flit;
      end
   end
endmodule

// File: tb/tb_pkt_router_buffered.sv
// tb/tb_pkt_router_buffered.sv - self-checking bench for pkt_router_buffered
// Per-port queues model expected output; a packet-level mode tracks head/body/discard.
module tb_pkt_router_buffered;
   localparam int NP = 4;
   localparam int DEPTH = 4;
   localparam int F = 11;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   logic              in_valid, in_ready, in_eop;
   logic [1:0]        in_dest, in_type;
   logic [7:0]        in_data;
   logic [NP-1:0]     out_valid, out_ready;
   logic [NP*F-1:0]   out_flit;
   logic              invalid_packet;
   logic [7:0]        drop_count;

   logic              in_valid3, in_ready3, in_eop3;
   logic [1:0]        in_dest3, in_type3;
   logic [7:0]        in_data3;
   logic [2:0]        out_valid3, out_ready3;
   logic [3*F-1:0]    out_flit3;
   logic              invalid_packet3;
   logic [7:0]        drop_count3;

   pkt_router_buffered dut (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_dest(in_dest), .in_type(in_type), .in_data(in_data), .in_eop(in_eop),
      .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
      .invalid_packet(invalid_packet), .drop_count(drop_count)
   );

   pkt_router_buffered #(.NUM_PORTS(3)) dut3 (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_dest(in_dest3), .in_type(in_type3), .in_data(in_data3), .in_eop(in_eop3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_flit(out_flit3),
      .invalid_packet(invalid_packet3), .drop_count(drop_count3)
   );

   int errors = 0;
   int checks = 0;

   logic [F-1:0] mq [NP][$];
   int           m_mode;   // 0 awaiting head, 1 inside routed packet, 2 discarding
   logic [1:0]   m_dest, m_type;
   logic         m_inv;
   int           m_drop;

   function automatic logic head_bad();
      return (in_type == 2'b11) || (int'(in_dest) >= NP);
   endfunction

   function automatic logic exp_ready();
      if (m_mode == 2) return 1'b1;
      if (m_mode == 1) return mq[m_dest].size() < DEPTH;
      if (head_bad()) return 1'b1;
      return mq[in_dest].size() < DEPTH;
   endfunction

   function automatic logic [NP-1:0] exp_valid();
      logic [NP-1:0] v;
      for (int p = 0; p < NP; p++) v[p] = (mq[p].size() != 0);
      return v;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) mq[p].delete();
      m_mode = 0; m_dest = 0; m_type = 0; m_inv = 0; m_drop = 0;
   endtask

   task automatic step();
      logic acc;
      acc = in_valid && exp_ready();
      for (int p = 0; p < NP; p++)
         if (mq[p].size() != 0 && out_ready[p]) void'(mq[p].pop_front());
      m_inv = 1'b0;
      if (acc) begin
         if (m_mode == 0) begin
            if (head_bad()) begin
               m_inv = 1'b1;
               if (m_drop < 255) m_drop++;
               m_mode = in_eop ? 0 : 2;
            end else begin
               mq[in_dest].push_back({in_eop, in_type, in_data});
               if (!in_eop) begin m_mode = 1; m_dest = in_dest; m_type = in_type; end
            end
         end else if (m_mode == 1) begin
            mq[m_dest].push_back({in_eop, m_type, in_data});
            if (in_eop) m_mode = 0;
         end else if (in_eop) begin
            m_mode = 0;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_dest = 0; in_type = 0; in_data = 0; in_eop = 0; out_ready = '1;
      in_valid3 = 0; in_dest3 = 0; in_type3 = 0; in_data3 = 0; in_eop3 = 0; out_ready3 = '1;
   endtask

   task automatic apply_reset();
      idle_inputs();
      n_rst = 0;
      model_reset();
      @(posedge clk); #3;
      n_rst = 1;
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (out_valid !== 4'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
      checks++; if (invalid_packet !== 1'b0) begin errors++; $display("FAIL reset_invalid got=%b exp=0", invalid_packet); end
      checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid3 !== 3'b0) begin errors++; $display("FAIL reset_out_valid3 got=%b exp=000", out_valid3); end
   endtask

   task automatic test_single();
      in_valid = 1; in_dest = 2'd1; in_type = 2'd1; in_data = 8'hAB; in_eop = 1; out_ready = '1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
      step();
      in_valid = 0;
      #1;
      checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL single_out_valid got=%b exp=0010", out_valid); end
      checks++; if (out_flit[1*F +: F] !== 11'b1_01_10101011) begin errors++; $display("FAIL single_flit got=%h exp=%h", out_flit[1*F +: F], 11'b1_01_10101011); end
      step();
      checks++; if (out_valid !== 4'b0) begin errors++; $display("FAIL single_drained got=%b exp=0000", out_valid); end
   endtask

   task automatic test_multi_flit();
      logic [7:0] d [3];
      logic [1:0] dst [3];
      logic [1:0] typ [3];
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
      dst[0] = 2'd2; dst[1] = 2'd1; dst[2] = 2'd0;
      typ[0] = 2'd0; typ[1] = 2'd3; typ[2] = 2'd1;
      out_ready = '0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_dest = dst[i]; in_type = typ[i]; in_data = d[i]; in_eop = (i == 2);
         #1;
         step();
      end
      in_valid = 0;
      #1;
      checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL multi_out_valid got=%b exp=0100", out_valid); end
      out_ready = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (out_valid[2] !== 1'b1 || out_flit[2*F +: F] !== {(i == 2), 2'b00, d[i]}) begin
            errors++; $display("FAIL multi_flit%0d got=%b/%h exp=1/%h", i, out_valid[2], out_flit[2*F +: F], {(i == 2), 2'b00, d[i]});
         end
         step();
      end
      checks++; if (out_valid !== 4'b0) begin errors++; $display("FAIL multi_drained got=%b exp=0000", out_valid); end
   endtask

   task automatic test_backpressure();
      int sent = 0;
      int got = 0;
      int cyc = 0;
      out_ready = '0;
      while (got < 6 && cyc < 60) begin
         in_valid = (sent < 6); in_dest = 0; in_type = 0; in_data = 8'h40 + 8'(sent); in_eop = 1;
         out_ready[0] = (cyc >= 8);
         #1;
         if (cyc >= 4 && cyc <= 8) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_c%0d got=%b exp=0", cyc, in_ready); end
         end
         if (cyc == 9) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume got=%b exp=1", in_ready); end
         end
         if (out_valid[0] && out_ready[0]) begin
            checks++;
            if (out_flit[F-1:0] !== {1'b1, 2'b00, 8'h40 + 8'(got)}) begin
               errors++; $display("FAIL bp_order%0d got=%h exp=%h", got, out_flit[F-1:0], {1'b1, 2'b00, 8'h40 + 8'(got)});
            end
            got++;
         end
         if (in_valid && in_ready) sent++;
         step();
         cyc++;
      end
      in_valid = 0;
      checks++; if (got != 6 || sent != 6) begin errors++; $display("FAIL bp_count got=%0d/%0d exp=6/6", got, sent); end
   endtask

   task automatic test_invalid_type();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_dest = 2'd1; in_type = (i == 0) ? 2'b11 : 2'b00; in_data = 8'(i); in_eop = (i == 2);
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL inv_ready%0d got=%b exp=1", i, in_ready); end
         step();
         checks++; if (invalid_packet !== (i == 0)) begin errors++; $display("FAIL inv_pulse%0d got=%b exp=%b", i, invalid_packet, (i == 0)); end
         checks++; if (out_valid !== 4'b0) begin errors++; $display("FAIL inv_no_out%0d got=%b exp=0000", i, out_valid); end
      end
      checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL inv_drop got=%0d exp=1", drop_count); end
      in_valid = 1; in_dest = 2'd3; in_type = 2'd2; in_data = 8'h5A; in_eop = 1;
      #1;
      step();
      in_valid = 0;
      checks++; if (out_valid !== 4'b1000 || out_flit[3*F +: F] !== {1'b1, 2'b10, 8'h5A}) begin
         errors++; $display("FAIL inv_next got=%b/%h exp=1000/%h", out_valid, out_flit[3*F +: F], {1'b1, 2'b10, 8'h5A});
      end
      step();
   endtask

   task automatic test_dest_range();
      in_valid3 = 1; in_dest3 = 2'd3; in_type3 = 2'd0; in_data3 = 8'h99; in_eop3 = 1;
      #1;
      checks++; if (in_ready3 !== 1'b1) begin errors++; $display("FAIL dest3_ready got=%b exp=1", in_ready3); end
      step();
      in_valid3 = 0;
      checks++; if (invalid_packet3 !== 1'b1) begin errors++; $display("FAIL dest3_pulse got=%b exp=1", invalid_packet3); end
      checks++; if (drop_count3 !== 8'd1) begin errors++; $display("FAIL dest3_drop got=%0d exp=1", drop_count3); end
      checks++; if (out_valid3 !== 3'b0) begin errors++; $display("FAIL dest3_no_out got=%b exp=000", out_valid3); end
      in_valid3 = 1; in_dest3 = 2'd2; in_type3 = 2'd1; in_data3 = 8'h77; in_eop3 = 1;
      #1;
      step();
      in_valid3 = 0;
      checks++; if (out_valid3 !== 3'b100 || out_flit3[2*F +: F] !== {1'b1, 2'b01, 8'h77}) begin
         errors++; $display("FAIL dest3_route got=%b/%h exp=100/%h", out_valid3, out_flit3[2*F +: F], {1'b1, 2'b01, 8'h77});
      end
      step();
   endtask

   task automatic test_reset_mid_packet();
      apply_reset();
      out_ready = '0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1; in_dest = 2'd3; in_type = 2'd0; in_data = 8'(i + 1); in_eop = 0;
         #1;
         step();
      end
      in_valid = 0;
      checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL mid_buffered got=%b exp=1000", out_valid); end
      #2;
      n_rst = 0;
      #1;
      checks++; if (out_valid !== 4'b0) begin errors++; $display("FAIL mid_async_clear got=%b exp=0000", out_valid); end
      model_reset();
      @(negedge clk);
      n_rst = 1;
      in_valid = 1; in_dest = 2'd0; in_type = 2'd1; in_data = 8'hC3; in_eop = 1; out_ready = '1;
      #1;
      step();
      in_valid = 0;
      checks++; if (out_valid !== 4'b0001 || out_flit[F-1:0] !== {1'b1, 2'b01, 8'hC3}) begin
         errors++; $display("FAIL mid_new_head got=%b/%h exp=0001/%h", out_valid, out_flit[F-1:0], {1'b1, 2'b01, 8'hC3});
      end
      step();
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_dest   = 2'($urandom);
         in_type   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         in_data   = 8'($urandom);
         in_eop    = ($urandom_range(0, 2) == 0);
         out_ready = 4'($urandom);
         #1;
         checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready c%0d got=%b exp=%b", c, in_ready, exp_ready()); end
         checks++; if (out_valid !== exp_valid()) begin errors++; $display("FAIL rnd_valid c%0d got=%b exp=%b", c, out_valid, exp_valid()); end
         for (int p = 0; p < NP; p++) begin
            if (mq[p].size() != 0) begin
               checks++;
               if (out_flit[p*F +: F] !== mq[p][0]) begin errors++; $display("FAIL rnd_flit c%0d p%0d got=%h exp=%h", c, p, out_flit[p*F +: F], mq[p][0]); end
            end
         end
         checks++; if (invalid_packet !== m_inv) begin errors++; $display("FAIL rnd_inv c%0d got=%b exp=%b", c, invalid_packet, m_inv); end
         checks++; if (drop_count !== 8'(m_drop)) begin errors++; $display("FAIL rnd_drop c%0d got=%0d exp=%0d", c, drop_count, m_drop); end
         step();
      end
      in_valid = 0; out_ready = '1;
      for (int c = 0; c < 8; c++) step();
      checks++; if (out_valid !== 4'b0) begin errors++; $display("FAIL rnd_drain got=%b exp=0000", out_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi_flit();
      test_backpressure();
      test_invalid_type();
      test_dest_range();
      test_reset_mid_packet();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule
